pipearch_result_packer: RTL and testbench
=========================================

Name: pipearch_result_packer

Overview:
Write-side endpoint for operator results (e.g. dot-product scalars). It accepts 32-bit result words through the we/wdata/almostfull protocol that operators drive, and buffers them in a FIFO. It packs 16 words per 512-bit line and issues line writes to the memory write channel at consecutive line addresses. It signals op_done once every line of the job has been issued and acknowledged.

Parameters:
WORD_WIDTH, 32, width of one result word
LOG2_WORDS_PER_LINE, 4, words per line = 16; line width = WORD_WIDTH << LOG2_WORDS_PER_LINE = 512
LOG2_FIFO_DEPTH, 6, input FIFO depth = 64 words
ALMOSTFULL_SLACK, 8, in_almostfull asserts when FIFO occupancy >= DEPTH - SLACK
ADDR_WIDTH, 42, line address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_start  in  1  one-cycle job start; honoured only in IDLE
regs0  in  ADDR_WIDTH  base line address, sampled on op_start
regs1  in  32  number of result words N, sampled on op_start
op_done  out  1  one-cycle pulse at job completion
in_we  in  1  result word valid
in_wdata  in  WORD_WIDTH  result word
in_almostfull  out  1  registered backpressure to the producer
mem_wr_valid  out  1  line write request
mem_wr_addr  out  ADDR_WIDTH  line address
mem_wr_data  out  512  packed line
mem_wr_ready  in  1  request accepted when valid && ready
mem_wr_ack  in  1  one write completion per pulse
overflow_err  out  1  sticky: in_we seen while FIFO full

Behaviour:
- Reset values: op_done=0, in_almostfull=0, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, overflow_err=0. FIFO is emptied; state=IDLE; all counters=0.
- Reset mid-job abandons the job. Outstanding acks arriving after reset are ignored; the outstanding counter stays 0 and must not underflow.
- FIFO write: in_we writes in_wdata in every state. If the FIFO is full, the word is dropped and overflow_err is set until reset.
- in_almostfull is registered from occupancy, so it lags by one cycle. The slack of 8 covers producer latency.
- States: IDLE, PACK, ISSUE, WAIT_ACK, DONE.
- IDLE to PACK on op_start. Latch base=regs0 and N=regs1. Clear word_idx, line_idx, lane and outstanding.
- If N==0, go IDLE to DONE directly.
- PACK: when the FIFO is non-empty, pop one word per cycle into lane `lane` (bits [32*lane +: 32]) of the line register. Then increment lane and word_idx.
- PACK to ISSUE when lane reaches 16, or when word_idx reaches N (partial last line).
- Unwritten lanes of a partial line are 0. The line register is cleared at the start of each line.
- ISSUE: mem_wr_valid=1, mem_wr_addr=base+line_idx, mem_wr_data=line. Address and data stay stable while valid && !ready.
- On handshake, line_idx++ and lane=0. If word_idx<N, go back to PACK; otherwise go to WAIT_ACK.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Outstanding counter (32-bit): +1 on handshake, -1 on mem_wr_ack. Simultaneous handshake and ack leave it unchanged.
- WAIT_ACK to DONE when outstanding==0, including the case where the final ack arrives in the same cycle as entry.
- DONE: op_done=1 for exactly one cycle, then IDLE.
- op_start outside IDLE is ignored.
- Lines issued per job = ceil(N/16). Throughput is one word per cycle in PACK plus at least one cycle per line in ISSUE.
- Words beyond N remain in the FIFO for the next job.

Test Plan:
- N=1, base=0x100, one word 0xDEADBEEF: one write at addr 0x100 with lane0=0xDEADBEEF, lanes1-15=0. Ack one cycle later: op_done pulses once.
- N=32, words 0..31, ready tied high, acks delayed 5 cycles: addr 0x100 carries 0..15 and 0x101 carries 16..31. op_done only after the 2nd ack.
- N=20, ready low for 10 cycles at first request: addr/data stable throughout the stall. Second line holds words 16-19 in lanes 0-3, all other lanes zero.
- Producer streams 64 words with mem_wr_ready=0: in_almostfull rises the cycle after occupancy hits 56. Writing a 65th word sets overflow_err and the FIFO keeps the first 64 words.
- N=0: op_done pulses 2 cycles after op_start with no mem_wr_valid. Also: assert reset mid-job with 1 outstanding line, then run a new job with N=16; op_done pulses after its single ack, and the stale ack is not counted.

Source files
------------

// File: rtl/pipearch_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : pipearch_result_packer
//  Description : Write-side endpoint for operator results. 32-bit result
//                words arrive through the we/wdata/almostfull interface and
//                are buffered in a FIFO. They are packed 16 per 512-bit line,
//                and each line is written to consecutive line addresses
//                starting at the job base. op_done pulses once every line of
//                the job has been issued and acknowledged.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                op_start/regs0/regs1 - job start, base line address, word count
//                op_done             - one-cycle completion pulse
//                in_we/in_wdata      - producer word stream
//                in_almostfull       - registered backpressure to producer
//                mem_wr_*            - line write channel (valid/ready, ack)
//                overflow_err        - sticky: word written while FIFO full
//  Revision    : 1.0 - initial release
// ============================================================================
module pipearch_result_packer #(
    parameter int WORD_WIDTH          = 32,
    parameter int LOG2_WORDS_PER_LINE = 4,
    parameter int LOG2_FIFO_DEPTH     = 6,
    parameter int ALMOSTFULL_SLACK    = 8,
    parameter int ADDR_WIDTH          = 42
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              op_start,
    input  logic [ADDR_WIDTH-1:0]                             regs0,
    input  logic [31:0]                                       regs1,
    output logic                                              op_done,
    input  logic                                              in_we,
    input  logic [WORD_WIDTH-1:0]                             in_wdata,
    output logic                                              in_almostfull,
    output logic                                              mem_wr_valid,
    output logic [ADDR_WIDTH-1:0]                             mem_wr_addr,
    output logic [(WORD_WIDTH<<LOG2_WORDS_PER_LINE)-1:0]      mem_wr_data,
    input  logic                                              mem_wr_ready,
    input  logic                                              mem_wr_ack,
    output logic                                              overflow_err
);

    localparam int WORDS_PER_LINE = 1 << LOG2_WORDS_PER_LINE;
    localparam int LINE_WIDTH     = WORD_WIDTH << LOG2_WORDS_PER_LINE;
    localparam int FIFO_DEPTH     = 1 << LOG2_FIFO_DEPTH;
    localparam int PTR_W          = LOG2_FIFO_DEPTH + 1;

    localparam logic [PTR_W-1:0] C_FIFO_DEPTH = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] C_AF_LEVEL   = PTR_W'(FIFO_DEPTH - ALMOSTFULL_SLACK);
    localparam logic [LOG2_WORDS_PER_LINE-1:0] C_LAST_LANE =
        LOG2_WORDS_PER_LINE'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PACK     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                           state_q, state_d;
    logic [ADDR_WIDTH-1:0]            base_q, base_d;
    logic [31:0]                      n_q, n_d;
    logic [31:0]                      word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0]            line_idx_q, line_idx_d;
    logic [LOG2_WORDS_PER_LINE-1:0]   lane_q, lane_d;
    logic [LINE_WIDTH-1:0]            line_q, line_d;
    logic [31:0]                      outstanding_q, outstanding_d;
    logic                             op_done_q, op_done_d;
    logic                             almostfull_q, almostfull_d;
    logic                             overflow_q, overflow_d;

    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [WORD_WIDTH-1:0]            fifo_mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Input FIFO. Pointers carry one extra bit so full and empty are distinct.
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WORD_WIDTH-1:0] fifo_rdata;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == C_FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_push  = in_we && !fifo_full;
    assign fifo_pop   = (state_q == S_PACK) && !fifo_empty;
    assign fifo_rdata = fifo_mem_q[rd_ptr_q[LOG2_FIFO_DEPTH-1:0]];

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(fifo_push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(fifo_pop);
        overflow_d   = overflow_q | (in_we & fifo_full);
        almostfull_d = (fifo_count >= C_AF_LEVEL);
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[LOG2_FIFO_DEPTH-1:0]] <= in_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding write counter. Acks with nothing outstanding (e.g. stale
    // acks from a job abandoned by reset) are ignored so it never underflows.
    // ------------------------------------------------------------------------
    logic handshake;
    logic start_accept;

    assign handshake    = (state_q == S_ISSUE) && mem_wr_ready;
    assign start_accept = (state_q == S_IDLE) && op_start;

    always_comb begin
        outstanding_d = outstanding_q;
        if (start_accept) begin
            outstanding_d = '0;
        end else begin
            unique case ({handshake, mem_wr_ack})
                2'b10:   outstanding_d = outstanding_q + 32'd1;
                2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 32'd1;
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Job FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        line_idx_d = line_idx_q;
        lane_d     = lane_q;
        line_d     = line_q;
        op_done_d  = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    base_d     = regs0;
                    n_d        = regs1;
                    word_idx_d = '0;
                    line_idx_d = '0;
                    lane_d     = '0;
                    line_d     = '0;
                    state_d    = (regs1 == '0) ? S_DONE : S_PACK;
                end
            end

            S_PACK: begin
                if (fifo_pop) begin
                    line_d[lane_q*WORD_WIDTH +: WORD_WIDTH] = fifo_rdata;
                    lane_d     = lane_q + 1'b1;
                    word_idx_d = word_idx_q + 32'd1;
                    // Line is complete when the last lane is filled or the
                    // job runs out of words (partial final line).
                    if ((lane_q == C_LAST_LANE) || (word_idx_d == n_q)) begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (handshake) begin
                    line_idx_d = line_idx_q + 1'b1;
                    lane_d     = '0;
                    line_d     = '0;
                    state_d    = (word_idx_q < n_q) ? S_PACK : S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                // Look at the next counter value so an ack landing on the
                // entry cycle completes the job without an extra cycle.
                if (outstanding_d == '0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            n_q           <= '0;
            word_idx_q    <= '0;
            line_idx_q    <= '0;
            lane_q        <= '0;
            line_q        <= '0;
            outstanding_q <= '0;
            op_done_q     <= 1'b0;
            almostfull_q  <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            n_q           <= n_d;
            word_idx_q    <= word_idx_d;
            line_idx_q    <= line_idx_d;
            lane_q        <= lane_d;
            line_q        <= line_d;
            outstanding_q <= outstanding_d;
            op_done_q     <= op_done_d;
            almostfull_q  <= almostfull_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Address and data come straight from registers, so they hold
    // steady while a request stalls.
    // ------------------------------------------------------------------------
    assign op_done       = op_done_q;
    assign in_almostfull = almostfull_q;
    assign overflow_err  = overflow_q;
    assign mem_wr_valid  = (state_q == S_ISSUE);
    assign mem_wr_addr   = base_q + line_idx_q;
    assign mem_wr_data   = line_q;

endmodule
`default_nettype wire

// File: tb/tb_pipearch_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipearch_result_packer
//  Description : Directed self-checking bench for pipearch_result_packer.
//                Inputs are driven 2 ns after the rising edge; a monitor on
//                the falling edge logs accepted line writes and op_done
//                pulses, and schedules acks a fixed number of cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipearch_result_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_start;
    logic [41:0]  regs0;
    logic [31:0]  regs1;
    logic         op_done;
    logic         in_we;
    logic [31:0]  in_wdata;
    logic         in_almostfull;
    logic         mem_wr_valid;
    logic [41:0]  mem_wr_addr;
    logic [511:0] mem_wr_data;
    logic         mem_wr_ready;
    logic         mem_wr_ack;
    logic         overflow_err;

    pipearch_result_packer dut (
        .clk           (clk),
        .reset         (reset),
        .op_start      (op_start),
        .regs0         (regs0),
        .regs1         (regs1),
        .op_done       (op_done),
        .in_we         (in_we),
        .in_wdata      (in_wdata),
        .in_almostfull (in_almostfull),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_ack    (mem_wr_ack),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cycle_no = 0;
    bit auto_ack = 1'b0;
    int ack_delay = 1;
    int ack_due[$];
    int ack_cycles[$];
    logic [41:0]  hs_addr[$];
    logic [511:0] hs_data[$];
    int done_cnt = 0;
    int done_cycle = -1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mem_wr_valid && mem_wr_ready) begin
            hs_addr.push_back(mem_wr_addr);
            hs_data.push_back(mem_wr_data);
            if (auto_ack) ack_due.push_back(cycle_no + ack_delay);
        end
        if (op_done) begin
            done_cnt   = done_cnt + 1;
            done_cycle = cycle_no;
        end
    end

    // Advance one cycle; drives the scheduled ack when auto acks are on.
    task automatic cyc();
        @(posedge clk);
        #2;
        cycle_no++;
        if (auto_ack) begin
            if (ack_due.size() > 0 && ack_due[0] <= cycle_no) begin
                ack_due.delete(0);
                mem_wr_ack = 1'b1;
                ack_cycles.push_back(cycle_no);
            end else begin
                mem_wr_ack = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        hs_addr.delete();
        hs_data.delete();
        ack_due.delete();
        ack_cycles.delete();
        done_cnt   = 0;
        done_cycle = -1;
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            in_we    = 1'b1;
            in_wdata = first + 32'(i);
        end
        cyc();
        in_we = 1'b0;
    endtask

    task automatic start_job(input logic [41:0] base, input logic [31:0] n);
        cyc();
        op_start = 1'b1;
        regs0    = base;
        regs1    = n;
        cyc();
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            cyc();
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 4; i++) cyc();
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] first, input int n);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[32*i +: 32] = first + 32'(i);
        return l;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; op_start = 1'b0; regs0 = '0; regs1 = '0;
        in_we = 1'b0; in_wdata = '0; mem_wr_ready = 1'b0; mem_wr_ack = 1'b0;
        cyc(); cyc(); cyc();
        n_cmp++; if (op_done !== 1'b0)       begin n_bad++; $display("FAIL rst_op_done got=%b exp=0", op_done); end
        n_cmp++; if (in_almostfull !== 1'b0) begin n_bad++; $display("FAIL rst_almostfull got=%b exp=0", in_almostfull); end
        n_cmp++; if (mem_wr_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid got=%b exp=0", mem_wr_valid); end
        n_cmp++; if (mem_wr_addr !== 42'd0)  begin n_bad++; $display("FAIL rst_addr got=%h exp=0", mem_wr_addr); end
        n_cmp++; if (mem_wr_data !== 512'd0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", mem_wr_data); end
        n_cmp++; if (overflow_err !== 1'b0)  begin n_bad++; $display("FAIL rst_overflow got=%b exp=0", overflow_err); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_word();
        bit to;
        clear_logs();
        auto_ack = 1'b1; ack_delay = 1; mem_wr_ready = 1'b1;
        push_words(32'hDEADBEEF, 1);
        start_job(42'h100, 32'd1);
        wait_done(60, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout got=%b exp=0", to); end
        n_cmp++; if (hs_addr.size() !== 1) begin n_bad++; $display("FAIL single_nlines got=%0d exp=1", hs_addr.size()); end
        if (hs_addr.size() >= 1) begin
            n_cmp++; if (hs_addr[0] !== 42'h100) begin n_bad++; $display("FAIL single_addr got=%h exp=100", hs_addr[0]); end
            n_cmp++; if (hs_data[0] !== 512'hDEADBEEF) begin n_bad++; $display("FAIL single_data got=%h exp=deadbeef", hs_data[0]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
        if (ack_cycles.size() >= 1) begin
            n_cmp++; if (done_cycle !== ack_cycles[0] + 2) begin n_bad++; $display("FAIL single_done_time got=%0d exp=%0d", done_cycle, ack_cycles[0] + 2); end
        end
    endtask

    task automatic test_two_lines();
        bit to;
        clear_logs();
        auto_ack = 1'b1; ack_delay = 5; mem_wr_ready = 1'b1;
        push_words(32'd0, 32);
        start_job(42'h100, 32'd32);
        wait_done(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL two_timeout got=%b exp=0", to); end
        n_cmp++; if (hs_addr.size() !== 2) begin n_bad++; $display("FAIL two_nlines got=%0d exp=2", hs_addr.size()); end
        if (hs_addr.size() >= 2) begin
            n_cmp++; if (hs_addr[0] !== 42'h100) begin n_bad++; $display("FAIL two_addr0 got=%h exp=100", hs_addr[0]); end
            n_cmp++; if (hs_data[0] !== make_line(32'd0, 16)) begin n_bad++; $display("FAIL two_data0 got=%h", hs_data[0]); end
            n_cmp++; if (hs_addr[1] !== 42'h101) begin n_bad++; $display("FAIL two_addr1 got=%h exp=101", hs_addr[1]); end
            n_cmp++; if (hs_data[1] !== make_line(32'd16, 16)) begin n_bad++; $display("FAIL two_data1 got=%h", hs_data[1]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL two_done_cnt got=%0d exp=1", done_cnt); end
        n_cmp++;
        if (ack_cycles.size() != 2 || done_cycle !== ack_cycles[1] + 2) begin
            n_bad++; $display("FAIL two_done_after_ack2 got=%0d acks=%0d", done_cycle, ack_cycles.size());
        end
    endtask

    task automatic test_stall_partial();
        bit to;
        bit seen;
        int stall_bad;
        logic [41:0]  a0;
        logic [511:0] d0;
        clear_logs();
        auto_ack = 1'b1; ack_delay = 2; mem_wr_ready = 1'b0;
        push_words(32'hA000, 20);
        start_job(42'h200, 32'd20);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc();
            if (mem_wr_valid) seen = 1'b1;
        end
        a0 = mem_wr_addr; d0 = mem_wr_data;
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL stall_valid_timeout got=%b exp=1", seen); end
        n_cmp++; if (a0 !== 42'h200 || d0 !== make_line(32'hA000, 16)) begin n_bad++; $display("FAIL stall_first_line addr=%h exp=200", a0); end
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!mem_wr_valid || mem_wr_addr !== a0 || mem_wr_data !== d0) stall_bad++;
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_stable got=%0d exp=0 changed cycles", stall_bad); end
        mem_wr_ready = 1'b1;
        wait_done(100, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout got=%b exp=0", to); end
        n_cmp++; if (hs_addr.size() !== 2) begin n_bad++; $display("FAIL stall_nlines got=%0d exp=2", hs_addr.size()); end
        if (hs_addr.size() >= 2) begin
            n_cmp++; if (hs_addr[1] !== 42'h201) begin n_bad++; $display("FAIL stall_addr1 got=%h exp=201", hs_addr[1]); end
            n_cmp++; if (hs_data[1] !== make_line(32'hA010, 4)) begin n_bad++; $display("FAIL stall_partial_data got=%h", hs_data[1]); end
        end
    endtask

    task automatic test_fifo_backpressure();
        bit to;
        int data_bad;
        clear_logs();
        auto_ack = 1'b1; ack_delay = 1; mem_wr_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            // Occupancy in this cycle is i; almostfull reflects i-1.
            if (i == 56) begin
                n_cmp++; if (in_almostfull !== 1'b0) begin n_bad++; $display("FAIL af_at_56 got=%b exp=0", in_almostfull); end
            end
            if (i == 57) begin
                n_cmp++; if (in_almostfull !== 1'b1) begin n_bad++; $display("FAIL af_at_57 got=%b exp=1", in_almostfull); end
            end
            in_we = 1'b1;
            in_wdata = 32'hF000 + 32'(i);
        end
        cyc();
        n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL ovf_before got=%b exp=0", overflow_err); end
        in_wdata = 32'hF040;
        cyc();
        in_we = 1'b0;
        n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
        mem_wr_ready = 1'b1;
        start_job(42'h500, 32'd64);
        wait_done(300, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ovf_job_timeout got=%b exp=0", to); end
        n_cmp++; if (hs_addr.size() !== 4) begin n_bad++; $display("FAIL ovf_nlines got=%0d exp=4", hs_addr.size()); end
        data_bad = 0;
        for (int l = 0; l < hs_data.size() && l < 4; l++) begin
            if (hs_data[l] !== make_line(32'hF000 + 32'(16*l), 16)) data_bad++;
            if (hs_addr[l] !== 42'h500 + 42'(l)) data_bad++;
        end
        n_cmp++; if (data_bad !== 0) begin n_bad++; $display("FAIL ovf_kept_first64 got=%0d exp=0 bad lines", data_bad); end
        n_cmp++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        auto_ack = 1'b1; mem_wr_ready = 1'b1;
        start_job(42'h600, 32'd0);
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_t1 got=%b exp=0", op_done); end
        cyc();
        n_cmp++; if (op_done !== 1'b1) begin n_bad++; $display("FAIL zero_done_t2 got=%b exp=1", op_done); end
        cyc();
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_t3 got=%b exp=0", op_done); end
        cyc(); cyc();
        n_cmp++; if (hs_addr.size() !== 0) begin n_bad++; $display("FAIL zero_no_write got=%0d exp=0", hs_addr.size()); end
    endtask

    task automatic test_reset_midjob();
        bit to;
        bit seen;
        clear_logs();
        auto_ack = 1'b0; mem_wr_ack = 1'b0; mem_wr_ready = 1'b1;
        push_words(32'h5000, 16);
        start_job(42'h300, 32'd16);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc();
            if (hs_addr.size() > 0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_issue_timeout got=%b exp=1", seen); end
        cyc(); cyc();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_cmp++; if (overflow_err !== 1'b0 || mem_wr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_clear ovf=%b valid=%b exp=0", overflow_err, mem_wr_valid); end
        cyc();
        mem_wr_ack = 1'b1;   // stale ack for the abandoned line
        cyc();
        mem_wr_ack = 1'b0;
        clear_logs();
        auto_ack = 1'b1; ack_delay = 1;
        push_words(32'h6000, 16);
        start_job(42'h400, 32'd16);
        wait_done(80, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL mid_timeout got=%b exp=0", to); end
        n_cmp++; if (hs_addr.size() !== 1) begin n_bad++; $display("FAIL mid_nlines got=%0d exp=1", hs_addr.size()); end
        if (hs_addr.size() >= 1) begin
            n_cmp++; if (hs_addr[0] !== 42'h400 || hs_data[0] !== make_line(32'h6000, 16)) begin n_bad++; $display("FAIL mid_line addr=%h exp=400", hs_addr[0]); end
        end
        n_cmp++;
        if (done_cnt !== 1 || ack_cycles.size() != 1 || done_cycle !== ack_cycles[0] + 2) begin
            n_bad++; $display("FAIL mid_done got=%0d pulses at %0d acks=%0d", done_cnt, done_cycle, ack_cycles.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_lines();
        test_stall_partial();
        test_zero_len();
        test_fifo_backpressure();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
